// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a sequencing controller and the bit-serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D_out;
   logic             B_out;
   logic             V_out;

   modport master (
      output start, A, B,
      input  busy, done, D_out, B_out, V_out
   );

   modport slave (
      input  start, A, B,
      output busy, done, D_out, B_out, V_out
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, one full-subtractor slice
// with a registered borrow. Results and flags hold until the next completed operation.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; operands captured on the accepting edge
// S_SHIFT  | one difference bit per cycle through the borrow slice
// S_FINISH | single cycle: publish difference, borrow, overflow; pulse done
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             bw;
   logic             sign_a;
   logic             sign_b;
   logic [CW-1:0]    count;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] d_out_r;
   logic             b_out_r;
   logic             v_out_r;

   logic d_bit;
   logic bw_next;

   // Full-subtractor slice: borrow out when a < b + borrow_in.
   always_comb begin
      d_bit   = a_sh[0] ^ b_sh[0] ^ bw;
      bw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         bw      <= 1'b0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         count   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         d_out_r <= '0;
         b_out_r <= 1'b0;
         v_out_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               if (bus.start) begin
                  a_sh   <= bus.A;
                  b_sh   <= bus.B;
                  sign_a <= bus.A[WIDTH-1];
                  sign_b <= bus.B[WIDTH-1];
                  bw     <= 1'b0;
                  count  <= '0;
                  busy_r <= 1'b1;
                  state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               done_r <= 1'b0;
               res_sh <= {d_bit, res_sh[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               bw     <= bw_next;
               count  <= count + 1'b1;
               if (count == LAST_BIT) begin
                  busy_r <= 1'b0;
                  state  <= S_FINISH;
               end
            end
            S_FINISH: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               d_out_r <= res_sh;
               b_out_r <= bw;
               // Overflow only possible when operand signs differ and the result sign flips from A's.
               v_out_r <= (sign_a != sign_b) & (res_sh[WIDTH-1] != sign_a);
               state   <= S_IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.D_out = d_out_r;
   assign bus.B_out = b_out_r;
   assign bus.V_out = v_out_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, handshake corner
// sequences and random operands against an arithmetic reference model.
module tb_serial_subtractor;
   localparam int WIDTH = 8;
   localparam int LAT   = WIDTH + 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   serial_subtractor_if #(.WIDTH(WIDTH)) ifc ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
      logic       v;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, unsigned for difference/borrow, signed for overflow.
   function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] d, output logic bo, output logic v);
      int du;
      int ds;
      du = int'(a) - int'(b);
      ds = int'($signed(a)) - int'($signed(b));
      d  = du[7:0];
      bo = (du < 0);
      v  = (ds > 127) || (ds < -128);
   endfunction

   // Called at a negedge; pulses start for one cycle and waits for done.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] d, output logic bo, output logic v,
                         output int lat, output int bcyc);
      ifc.A     = a;
      ifc.B     = b;
      ifc.start = 1'b1;
      bcyc      = 0;
      @(negedge clk);
      ifc.start = 1'b0;
      lat = 1;
      if (ifc.busy) bcyc++;
      while (!ifc.done && lat < 30) begin
         @(negedge clk);
         lat++;
         if (ifc.busy) bcyc++;
      end
      d  = ifc.D_out;
      bo = ifc.B_out;
      v  = ifc.V_out;
   endtask

   initial begin
      logic [7:0] d, ed;
      logic       bo, v, ebo, ev;
      int         lat, bcyc, ndone, first_done, second_done;
      logic       hold_bad;

      checks   = 0;
      failures = 0;
      vecs[0] = '{a: 8'd100,  b: 8'd58,   d: 8'd42,   bo: 1'b0, v: 1'b0};
      vecs[1] = '{a: 8'd5,    b: 8'd9,    d: 8'hFC,   bo: 1'b1, v: 1'b0};
      vecs[2] = '{a: 8'h80,   b: 8'h01,   d: 8'h7F,   bo: 1'b0, v: 1'b1};
      vecs[3] = '{a: 8'h7F,   b: 8'hFF,   d: 8'h80,   bo: 1'b1, v: 1'b1};
      vecs[4] = '{a: 8'hA5,   b: 8'hA5,   d: 8'h00,   bo: 1'b0, v: 1'b0};
      vecs[5] = '{a: 8'h00,   b: 8'hFF,   d: 8'h01,   bo: 1'b1, v: 1'b0};

      ifc.start = 1'b0;
      ifc.A     = '0;
      ifc.B     = '0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy",  ifc.busy,  0);
      check("reset_done",  ifc.done,  0);
      check("reset_dout",  ifc.D_out, 0);
      check("reset_bout",  ifc.B_out, 0);
      check("reset_vout",  ifc.V_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, d, bo, v, lat, bcyc);
         check($sformatf("vec%0d_latency", i), lat, LAT);
         check($sformatf("vec%0d_busy_cycles", i), bcyc, WIDTH);
         check($sformatf("vec%0d_dout", i), d, vecs[i].d);
         check($sformatf("vec%0d_bout", i), bo, vecs[i].bo);
         check($sformatf("vec%0d_vout", i), v, vecs[i].v);
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), ifc.done, 0);
      end

      // start and operand changes while busy must be ignored
      ifc.A = 8'd20; ifc.B = 8'd3; ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 25; c++) begin
         if (c == 3) begin ifc.A = 8'd0; ifc.B = 8'd0; ifc.start = 1'b1; end
         if (c == 4) ifc.start = 1'b0;
         @(negedge clk);
         if (ifc.done) begin
            ndone++;
            check("ignore_dout", ifc.D_out, 8'd17);
         end
      end
      check("ignore_done_count", ndone, 1);

      // start held high: back-to-back operations
      ifc.A = 8'd50; ifc.B = 8'd20; ifc.start = 1'b1;
      ndone = 0; first_done = 0; second_done = 0; hold_bad = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin ifc.A = 8'd10; ifc.B = 8'd30; end
         if (ndone == 1 && c == first_done + 1) ifc.start = 1'b0;
         if (ndone == 1 && ifc.busy && ifc.D_out !== 8'd30) hold_bad = 1'b1;
         if (ifc.done) begin
            ndone++;
            if (ndone == 1) begin
               first_done = c;
               check("b2b_first_dout", ifc.D_out, 8'd30);
               check("b2b_first_bout", ifc.B_out, 0);
            end else if (ndone == 2) begin
               second_done = c;
               check("b2b_second_dout", ifc.D_out, 8'hEC);
               check("b2b_second_bout", ifc.B_out, 1);
            end
         end
      end
      ifc.start = 1'b0;
      check("b2b_done_count", ndone, 2);
      check("b2b_done_gap", second_done - first_done, LAT);
      check("b2b_hold_during_shift", hold_bad, 0);

      // asynchronous reset in the middle of SHIFT
      @(negedge clk);
      ifc.A = 8'd100; ifc.B = 8'd1; ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_busy_before", ifc.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",  ifc.busy,  0);
      check("midrst_done",  ifc.done,  0);
      check("midrst_dout",  ifc.D_out, 0);
      check("midrst_bout",  ifc.B_out, 0);
      check("midrst_vout",  ifc.V_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ifc.done || ifc.busy) ndone++;
      end
      check("midrst_no_activity", ndone, 0);
      run_op(8'd3, 8'd1, d, bo, v, lat, bcyc);
      check("midrst_after_latency", lat, LAT);
      check("midrst_after_dout", d, 8'd2);
      check("midrst_after_bout", bo, 0);
      @(negedge clk);

      // random operands against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if (i == 0) rb = ra;
         run_op(ra, rb, d, bo, v, lat, bcyc);
         model(ra, rb, ed, ebo, ev);
         check($sformatf("rand%0d_latency", i), lat, LAT);
         check($sformatf("rand%0d_dout a=%0h b=%0h", i, ra, rb), d, ed);
         check($sformatf("rand%0d_bout a=%0h b=%0h", i, ra, rb), bo, ebo);
         check($sformatf("rand%0d_vout a=%0h b=%0h", i, ra, rb), v, ev);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
